// File: rtl/code_rom_loader.sv
// Host-to-code-ROM frame loader: SYNC, 16-bit LEN, LEN payload bytes, XOR checksum.
// Payload is streamed into the ROM write port, then four 0xFF terminator bytes follow it.
module code_rom_loader #(
    parameter int unsigned ROM_BYTES = 516,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        hclk,
    input  logic        reset_code_rom_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_rom_mode,
    output logic [11:0] code_rom_addr_in,
    output logic [7:0]  code_rom_data_in,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned MAX_LEN = ROM_BYTES - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_TERM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [7:0]  xor_q;
    logic [1:0]  term_q;
    logic        rx_ready_q;
    logic        prog_q;
    logic [11:0] addr_q;
    logic [7:0]  data_q;
    logic        done_q;
    logic        err_q;

    logic        xfer_d;
    logic [15:0] len_d;
    logic        len_bad_d;
    logic [7:0]  xor_d;

    assign xfer_d    = rx_valid && rx_ready_q;
    assign len_d     = {rx_data, len_lo_q};
    assign len_bad_d = (32'(len_d) > MAX_LEN) || (len_d[1:0] != 2'b00);
    assign xor_d     = xor_q ^ rx_data;

    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q    <= S_IDLE;
            len_lo_q   <= 8'h00;
            len_q      <= 16'h0000;
            cnt_q      <= 16'h0000;
            xor_q      <= 8'h00;
            term_q     <= 2'd0;
            rx_ready_q <= 1'b0;
            prog_q     <= 1'b0;
            addr_q     <= 12'h000;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Ready everywhere except TERM; the TERM paths below override this.
            rx_ready_q <= 1'b1;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (xfer_d && rx_data == SYNC_BYTE) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        xor_q   <= 8'h00;
                        state_q <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer_d) begin
                        len_lo_q <= rx_data;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer_d) begin
                        len_q <= len_d;
                        cnt_q <= 16'h0000;
                        if (len_bad_d) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                            prog_q  <= 1'b0;
                        end else if (len_d == 16'h0000) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (xfer_d) begin
                        addr_q <= cnt_q[11:0];
                        data_q <= rx_data;
                        prog_q <= 1'b1;
                        xor_q  <= xor_d;
                        cnt_q  <= cnt_q + 16'd1;
                        if (cnt_q == len_q - 16'd1) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer_d) begin
                        if (rx_data == xor_q) begin
                            state_q    <= S_TERM;
                            rx_ready_q <= 1'b0;
                            addr_q     <= len_q[11:0];
                            data_q     <= 8'hFF;
                            prog_q     <= 1'b1;
                            term_q     <= 2'd0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                            prog_q  <= 1'b0;
                        end
                    end
                end
                S_TERM: begin
                    if (term_q == 2'd3) begin
                        state_q <= S_DONE;
                        prog_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rx_ready_q <= 1'b0;
                        addr_q     <= addr_q + 12'd1;
                        term_q     <= term_q + 2'd1;
                    end
                end
            endcase
        end
    end

    assign rx_ready         = rx_ready_q;
    assign program_rom_mode = prog_q;
    assign code_rom_addr_in = addr_q;
    assign code_rom_data_in = data_q;
    assign load_done        = done_q;
    assign load_error       = err_q;

endmodule

// File: tb/tb_code_rom_loader.sv
// Self-checking bench for code_rom_loader: directed frames plus randomized frames
// checked against a frame-level model of the expected ROM write sequence and flags.
module tb_code_rom_loader;

    localparam int ROM_BYTES = 516;

    logic        hclk = 1'b0;
    logic        reset_code_rom_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        program_rom_mode;
    logic [11:0] code_rom_addr_in;
    logic [7:0]  code_rom_data_in;
    logic        load_done;
    logic        load_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] wr_q[$];
    logic        prev_prog = 1'b0;
    logic [19:0] prev_pair = 20'h0;

    code_rom_loader #(.ROM_BYTES(ROM_BYTES), .SYNC_BYTE(8'hA5)) dut (
        .hclk             (hclk),
        .reset_code_rom_n (reset_code_rom_n),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .program_rom_mode (program_rom_mode),
        .code_rom_addr_in (code_rom_addr_in),
        .code_rom_data_in (code_rom_data_in),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Harness view: every cycle with program_rom_mode high is a ROM write; log each new pair.
    always @(negedge hclk) begin
        if (reset_code_rom_n && program_rom_mode) begin
            if (!prev_prog || {code_rom_addr_in, code_rom_data_in} != prev_pair)
                wr_q.push_back({code_rom_addr_in, code_rom_data_in});
        end
        prev_prog <= reset_code_rom_n && program_rom_mode;
        prev_pair <= {code_rom_addr_in, code_rom_data_in};
        if (reset_code_rom_n)
            check("flags_exclusive", 32'(load_done & load_error), 0);
    end

    function automatic logic [31:0] all_outs();
        return 32'({rx_ready, program_rom_mode, code_rom_addr_in, code_rom_data_in,
                    load_done, load_error});
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        logic rdy;
        @(negedge hclk);
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            rdy = rx_ready;
            @(posedge hclk);
            if (rdy) break;
            waited++;
            if (waited > 20) break;
            @(negedge hclk);
        end
        check("full_rate_accept", 32'(waited), 0);
    endtask

    task automatic do_reset();
        @(negedge hclk);
        rx_valid = 1'b0;
        reset_code_rom_n = 1'b0;
        #1 check("reset_outputs", all_outs(), 0);
        @(negedge hclk);
        reset_code_rom_n = 1'b1;
        #1 check("ready_before_edge", 32'(rx_ready), 0);
        @(negedge hclk);
        check("ready_after_edge", 32'(rx_ready), 1);
        wr_q.delete();
    endtask

    // Model: accepted length -> payload writes at 0..LEN-1; good checksum -> FF at LEN..LEN+3.
    task automatic run_frame(input string name, input logic [15:0] len, input logic [7:0] fixed[$],
                             input logic [7:0] chk_flip, input int garbage,
                             input int gap_min, input int gap_max);
        logic [7:0]  x = 8'h00;
        logic [7:0]  b;
        logic [19:0] exp_q[$];
        bit          len_bad;
        bit          fail_exp;
        int          g;
        int          mism = 0;
        len_bad  = (int'(len) > ROM_BYTES - 4) || (len[1:0] != 2'b00);
        fail_exp = len_bad || (chk_flip != 8'h00);
        wr_q.delete();
        for (int i = 0; i < garbage; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
        end
        send_byte(8'hA5);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (!len_bad) begin
            for (int k = 0; k < int'(len); k++) begin
                b = (fixed.size() != 0) ? fixed[k] : 8'($urandom_range(0, 255));
                x ^= b;
                exp_q.push_back({12'(k), b});
                send_byte(b);
                g = $urandom_range(gap_min, gap_max);
                repeat (g) begin
                    @(negedge hclk);
                    rx_valid = 1'b0;
                    check({name, ":gap_hold"},
                          32'({program_rom_mode, code_rom_addr_in, code_rom_data_in}),
                          32'({1'b1, 12'(k), b}));
                end
            end
            send_byte(x ^ chk_flip);
        end
        @(negedge hclk);
        rx_valid = 1'b0;
        if (fail_exp) begin
            check({name, ":error"}, 32'(load_error), 1);
            check({name, ":done"}, 32'(load_done), 0);
            check({name, ":prog_off"}, 32'(program_rom_mode), 0);
            check({name, ":ready"}, 32'(rx_ready), 1);
        end else begin
            check({name, ":ready_in_term"}, 32'(rx_ready), 0);
            check({name, ":first_term"},
                  32'({program_rom_mode, code_rom_addr_in, code_rom_data_in}),
                  32'({1'b1, len[11:0], 8'hFF}));
            repeat (4) @(negedge hclk);
            check({name, ":done"}, 32'(load_done), 1);
            check({name, ":error"}, 32'(load_error), 0);
            check({name, ":prog_off"}, 32'(program_rom_mode), 0);
            check({name, ":ready"}, 32'(rx_ready), 1);
            for (int i = 0; i < 4; i++)
                exp_q.push_back({len[11:0] + 12'(i), 8'hFF});
        end
        repeat (2) @(negedge hclk);
        check({name, ":n_writes"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) mism++;
        check({name, ":write_seq"}, 32'(mism), 0);
    endtask

    initial begin
        logic [7:0]  pay[$];
        logic [7:0]  none[$];
        logic [15:0] len;
        logic [7:0]  flip;
        int          kind;
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        do_reset();

        // Garbage in IDLE, then an empty program: only the terminator is written.
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_ignored", 32'(load_done | load_error | program_rom_mode), 0);
        run_frame("len0", 16'd0, none, 8'h00, 0, 0, 0);

        run_frame("basic", 16'd8, pay, 8'h00, 0, 0, 0);
        // Checksum of this payload is 0x90; flipping by 0x91 sends 0x01.
        run_frame("bad_chk", 16'd8, pay, 8'h91, 0, 0, 0);
        run_frame("len_0206", 16'h0206, none, 8'h00, 0, 0, 0);
        run_frame("len_0006", 16'h0006, none, 8'h00, 0, 0, 0);
        run_frame("gap2", 16'd8, pay, 8'h00, 0, 2, 2);

        // Abandon a frame mid-payload with an asynchronous reset.
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(pay[i]);
        @(negedge hclk);
        rx_valid = 1'b0;
        #2 reset_code_rom_n = 1'b0;
        #1 check("async_reset", all_outs(), 0);
        @(negedge hclk);
        check("reset_held", all_outs(), 0);
        reset_code_rom_n = 1'b1;
        @(negedge hclk);
        check("ready_after_reset", 32'(rx_ready), 1);
        wr_q.delete();
        run_frame("after_reset", 16'd8, pay, 8'h00, 0, 0, 0);

        run_frame("len_max", 16'(ROM_BYTES - 4), none, 8'h00, 1, 0, 0);
        run_frame("len_max_p4", 16'(ROM_BYTES), none, 8'h00, 0, 0, 0);

        for (int f = 0; f < 25; f++) begin
            kind = $urandom_range(0, 5);
            len  = 16'(4 * $urandom_range(0, 16));
            flip = 8'h00;
            if (kind == 0) begin
                flip = 8'($urandom_range(1, 255));
            end else if (kind == 1) begin
                if ($urandom_range(0, 1) == 0)
                    len = len + 16'($urandom_range(1, 3));
                else
                    len = 16'(ROM_BYTES - 3 + $urandom_range(0, 100));
            end
            run_frame($sformatf("rand%0d", f), len, none, flip,
                      $urandom_range(0, 2), 0, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
